execute_unit: RTL
=================

// Module: execute_unit
// PURPOSE
//  Execute stage between the 32x32 register file read ports and its write port.
//  Takes two operands plus a destination index, computes one ALU or multiply result,
//  and drives the register file write port (writeReg/writeData) for exactly one cycle.
//  Single-cycle ops finish in one clock. MUL is an iterative shift-add sequence that
//  stalls the upstream stage through in_ready.
// PARAMETERS
//  DATA_W   32  operand/result width; MUL iterates DATA_W cycles
//  ADDR_W    5  register index width
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  in_valid    in   1       op/rs1_data/rs2_data/rd valid
//  in_ready    out  1       unit can accept; transfer = in_valid & in_ready at posedge
//  op          in   4       0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA,10 MUL
//  rs1_data    in   DATA_W  operand A (register file readData1)
//  rs2_data    in   DATA_W  operand B (register file readData2)
//  rd          in   ADDR_W  destination register index
//  wb_reg      out  ADDR_W  to register file writeReg
//  wb_data     out  DATA_W  to register file writeData
//  wb_valid    out  1       result valid this cycle
//  busy        out  1       multiply in progress
//  illegal_op  out  1       one-cycle pulse on an unsupported op
// BEHAVIOUR
//  - Reset: state IDLE. in_ready=1. wb_reg=0, wb_data=0, wb_valid=0, busy=0, illegal_op=0.
//    The counter and partial product are cleared.
//  - The register file writes on every clock whenever writeReg != 0. So wb_reg MUST be 0
//    in every cycle where wb_valid=0. wb_data is 0 when wb_valid=0.
//  - rd=0 on an accepted op: wb_valid still pulses, wb_reg=0, and no write occurs.
//  - All outputs are registered. No combinational path from inputs to outputs, except
//    in_ready, which depends on state only.
//  - FSM IDLE: in_ready=1.
//    - Accept a single-cycle op: the next cycle has wb_valid=1, wb_reg=rd, wb_data=result.
//      Stay in IDLE. Back-to-back accepts give back-to-back writebacks.
//    - Accept MUL: go to MUL_RUN.
//    - Accept op 11-15: illegal_op=1 for one cycle, wb_valid=0, no state change.
//  - FSM MUL_RUN: in_ready=0, busy=1.
//    - Latch A, B and rd at accept; acc=0, cnt=0.
//    - Each cycle: if B[0], acc += A. Then A <<= 1, B >>= 1, cnt++.
//    - After DATA_W iterations go to MUL_DONE.
//  - FSM MUL_DONE: wb_valid=1, wb_reg=rd, wb_data=acc[DATA_W-1:0], busy=0, in_ready=1.
//    - A new accept in this cycle is legal and handled as from IDLE. Otherwise go to IDLE.
//    - Total MUL latency: wb_valid is high in cycle DATA_W+1 after the accept edge.
//  - Arithmetic:
//    - All results are mod 2^DATA_W. No overflow or carry flags.
//    - SLT compares signed, SLTU unsigned; the result is 0 or 1 zero-extended.
//    - Shift amount is rs2_data[4:0]. SRA replicates rs1_data[31].
//    - MUL returns the low DATA_W bits of the product; signed and unsigned are identical.
//  - Inputs are ignored while in_ready=0; upstream must hold them.
//  - rst asserted mid-MUL aborts the operation. No wb_valid pulse follows.
//    Outputs take reset values asynchronously.
// CONFIGURATION
//  MUL_EN defined:     MUL datapath and states MUL_RUN/MUL_DONE are built as above.
//  MUL_EN not defined: no multiplier logic. Op 10 is treated like ops 11-15
//                      (illegal_op pulse, no writeback). busy is tied to 0 and
//                      in_ready to 1.
// TESTING
//  1. ADD rs1=FFFFFFFF rs2=00000001 rd=3 -> next cycle wb_valid=1, wb_reg=3, wb_data=0.
//     The following cycle wb_reg=0.
//  2. SLT rs1=FFFFFFFF rs2=1 rd=4 -> wb_data=1. SLTU with the same operands -> wb_data=0.
//     SRA of 80000000 by 4 -> F8000000.
//  3. MUL_EN: MUL 00012345 x 00000100 rd=7 -> in_ready=0 and busy=1 for 32 cycles,
//     then wb_valid=1, wb_data=01234500. A new ADD is accepted in the same cycle and
//     writes back the next cycle.
//  4. MUL_EN: rst pulsed 10 cycles into a MUL -> all outputs 0 immediately, in_ready=1
//     after release, no wb_valid for that MUL.
//  5. op=12 rd=5 -> illegal_op=1 for one cycle, wb_valid=0, wb_reg=0.
//     Without MUL_EN, op=10 behaves the same.
//  6. ADD with rd=0 -> wb_valid=1, wb_reg=0. Register file contents unchanged.
//     8 back-to-back ADDs -> 8 consecutive wb_valid cycles.

Source files
------------

// File: rtl/execute_if.sv
// Execute-stage bus: operand/op handshake from issue plus the register-file writeback side.
interface execute_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              busy;
  logic              illegal_op;

  modport master (
    output in_valid, op, rs1_data, rs2_data, rd,
    input  in_ready, wb_reg, wb_data, wb_valid, busy, illegal_op
  );

  modport slave (
    input  in_valid, op, rs1_data, rs2_data, rd,
    output in_ready, wb_reg, wb_data, wb_valid, busy, illegal_op
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU ops plus an optional iterative shift-add MUL.
// Define MUL_EN to build the multiplier; otherwise op 10 is reported as illegal.
module execute_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  execute_if.slave io
);
  localparam int SH_W = $clog2(DATA_W);

  logic              accept, alu_legal, op_mul;
  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] alu_res;

  logic              mul_fin;
  logic [DATA_W-1:0] mul_res;
  logic [ADDR_W-1:0] mul_rd;

  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              illegal_q, illegal_d;

  assign accept    = io.in_valid & io.in_ready;
  assign alu_legal = (io.op <= 4'd9);
  assign sh        = io.rs2_data[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    case (io.op)
      4'd0:    alu_res = io.rs1_data + io.rs2_data;
      4'd1:    alu_res = io.rs1_data - io.rs2_data;
      4'd2:    alu_res = io.rs1_data & io.rs2_data;
      4'd3:    alu_res = io.rs1_data | io.rs2_data;
      4'd4:    alu_res = io.rs1_data ^ io.rs2_data;
      4'd5:    alu_res = DATA_W'($signed(io.rs1_data) < $signed(io.rs2_data));
      4'd6:    alu_res = DATA_W'(io.rs1_data < io.rs2_data);
      4'd7:    alu_res = io.rs1_data << sh;
      4'd8:    alu_res = io.rs1_data >> sh;
      4'd9:    alu_res = DATA_W'($signed(io.rs1_data) >>> sh);
      default: alu_res = '0;
    endcase
  end

`ifdef MUL_EN
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] mrd_q, mrd_d;
  logic              last_iter;

  assign op_mul    = (io.op == 4'd10);
  assign last_iter = (cnt_q == SH_W'(DATA_W-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mrd_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mrd_q   <= mrd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mrd_d   = mrd_q;
    case (state_q)
      MUL_RUN: begin
        acc_d = acc_q + (b_q[0] ? a_q : '0);
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = MUL_DONE;
      end
      default: begin
        // MUL_DONE accepts exactly like IDLE so the next op is not delayed.
        state_d = IDLE;
        if (accept && op_mul) begin
          state_d = MUL_RUN;
          a_d     = io.rs1_data;
          b_d     = io.rs2_data;
          acc_d   = '0;
          cnt_d   = '0;
          mrd_d   = io.rd;
        end
      end
    endcase
  end

  assign mul_fin     = (state_q == MUL_RUN) && last_iter;
  assign mul_res     = acc_d;
  assign mul_rd      = mrd_q;
  assign io.in_ready = (state_q != MUL_RUN);
  assign io.busy     = (state_q == MUL_RUN);
`else
  assign op_mul      = 1'b0;
  assign mul_fin     = 1'b0;
  assign mul_res     = '0;
  assign mul_rd      = '0;
  assign io.in_ready = 1'b1;
  assign io.busy     = 1'b0;
`endif

  // wb_reg must be zero whenever wb_valid is low: the register file writes on any nonzero index.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_reg_d   = '0;
    wb_data_d  = '0;
    illegal_d  = 1'b0;
    if (mul_fin) begin
      wb_valid_d = 1'b1;
      wb_reg_d   = mul_rd;
      wb_data_d  = mul_res;
    end else if (accept) begin
      if (alu_legal) begin
        wb_valid_d = 1'b1;
        wb_reg_d   = io.rd;
        wb_data_d  = alu_res;
      end else if (!op_mul) begin
        illegal_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
    end
  end

  assign io.wb_valid   = wb_valid_q;
  assign io.wb_reg     = wb_reg_q;
  assign io.wb_data    = wb_data_q;
  assign io.illegal_op = illegal_q;
endmodule
